sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 10 +
 rtl/sync_fifo_mem.sv | 30 +++
 rtl/sync_fifo.sv | 121 ++++++++++++
 tb/tb_sync_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Build-time options for sync_fifo. Defining SYNC_FIFO_FWFT_EN selects first-word-fall-through mode.
package sync_fifo_pkg;

`ifdef SYNC_FIFO_FWFT_EN
  localparam bit FWFT_MODE = 1'b1;
`else
  localparam bit FWFT_MODE = 1'b0;
`endif

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: one write port, one registered read port. Array is never cleared.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] ram [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
  end

  // Read-before-write on a shared address; only the read register is reset.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= ram[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered flags and sticky error bits.
// SYNC_FIFO_FWFT_EN (via sync_fifo_pkg::FWFT_MODE) builds the first-word-fall-through variant.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_BITS  = 5,
  parameter int AFULL_LVL  = (2**ADDR_BITS) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_BITS:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_BITS + 1;
  localparam logic [ADDR_BITS:0] DEPTH_C  = CW'(2**ADDR_BITS);
  localparam logic [ADDR_BITS:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [ADDR_BITS:0] AEMPTY_C = CW'(AEMPTY_LVL);

  logic [ADDR_BITS-1:0]  wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]    count_next;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_acc, rd_acc, ram_re;

  // Handshake: a read is taken when rd_en=1 and empty=0; a write is taken when
  // wr_en=1 and either not full or a read is taken at the same edge.
  // Any request not taken sets its sticky error bit.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + ADDR_BITS'(wr_acc);
      rd_ptr       <= rd_ptr + ADDR_BITS'(ram_re);
      count        <= count_next;
      full         <= (count_next == DEPTH_C);
      almost_full  <= (count_next >= AFULL_C);
      almost_empty <= (count_next <= AEMPTY_C);
      overflow     <= overflow  | (wr_en & ~wr_acc);
      underflow    <= underflow | (rd_en & ~rd_acc);
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  if (FWFT_MODE) begin : g_fwft
    // Two-stage prefetch: RAM read register (stage a) feeds the output register.
    // count covers words in RAM, in stage a and in the output register.
    logic [ADDR_BITS:0]    ram_cnt;
    logic                  a_valid, a_to_out;
    logic [DATA_WIDTH-1:0] out_q;

    assign a_to_out = a_valid & (empty | rd_acc);
    assign ram_re   = (ram_cnt != '0) & (~a_valid | a_to_out);
    assign rd_data  = out_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        ram_cnt <= '0;
        a_valid <= 1'b0;
        out_q   <= '0;
        empty   <= 1'b1;
      end else begin
        ram_cnt <= ram_cnt + CW'(wr_acc) - CW'(ram_re);
        a_valid <= ram_re | (a_valid & ~a_to_out);
        if (a_to_out) out_q <= mem_rdata;
        empty   <= ~(a_to_out | (~empty & ~rd_acc));
      end
    end
  end else begin : g_std
    assign ram_re  = rd_acc;
    assign rd_data = mem_rdata;

    always_ff @(posedge clk) begin
      if (reset) empty <= 1'b1;
      else       empty <= (count_next == '0);
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DATA_WIDTH=16, ADDR_BITS=2, AFULL_LVL=3, AEMPTY_LVL=1).
// Compile with SYNC_FIFO_FWFT_EN to exercise the first-word-fall-through build.
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        full, empty, almost_full, almost_empty, overflow, underflow;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;
  bit model_on = 1'b0;

  // Behavioural model: a queue of stored words plus sticky flags and last-read word.
  logic [15:0] exp_q[$];
  logic [15:0] m_rd_data = '0;
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;

  sync_fifo #(
    .DATA_WIDTH (16),
    .ADDR_BITS  (2),
    .AFULL_LVL  (3),
    .AEMPTY_LVL (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one edge and advance the model by the FIFO's acceptance rules.
  task automatic cycle(input logic we, input logic [15:0] wd, input logic re, input logic rst);
    bit rd_ok, wr_ok;
    wr_en = we; wr_data = wd; rd_en = re; reset = rst;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_rd_data = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rd_ok = re && (exp_q.size() > 0);
      wr_ok = we && ((exp_q.size() < 4) || rd_ok);
      if (rd_ok) m_rd_data = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(wd);
      if (we && !wr_ok) m_ovf = 1'b1;
      if (re && !rd_ok) m_udf = 1'b1;
    end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("model_count",  32'(count),        32'(exp_q.size()));
      chk("model_full",   32'(full),         32'(exp_q.size() == 4));
      chk("model_empty",  32'(empty),        32'(exp_q.size() == 0));
      chk("model_afull",  32'(almost_full),  32'(exp_q.size() >= 3));
      chk("model_aempty", 32'(almost_empty), 32'(exp_q.size() <= 1));
      chk("model_ovf",    32'(overflow),     32'(m_ovf));
      chk("model_udf",    32'(underflow),    32'(m_udf));
      chk("model_rdata",  32'(rd_data),      32'(m_rd_data));
    end
  end

  initial begin
`ifdef SYNC_FIFO_FWFT_EN
    cycle(0, 16'h0, 0, 1);
    cycle(0, 16'h0, 0, 1);
    chk("fwft_reset_empty", 32'(empty), 32'd1);
    cycle(1, 16'hCAFE, 0, 0);
    chk("fwft_n_empty", 32'(empty), 32'd1);
    cycle(0, 16'h0, 0, 0);
    chk("fwft_n1_empty", 32'(empty), 32'd1);
    cycle(0, 16'h0, 0, 0);
    chk("fwft_n2_empty", 32'(empty), 32'd0);
    chk("fwft_n2_rdata", 32'(rd_data), 32'h0000CAFE);
    chk("fwft_n2_count", 32'(count), 32'd1);
    cycle(0, 16'h0, 1, 0);
    chk("fwft_pop_empty", 32'(empty), 32'd1);
    chk("fwft_pop_count", 32'(count), 32'd0);
    chk("fwft_pop_udf", 32'(underflow), 32'd0);
`else
    cycle(0, 16'h0, 0, 1);
    model_on = 1'b1;
    cycle(0, 16'h0, 0, 1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_aempty", 32'(almost_empty), 32'd1);
    chk("reset_rdata", 32'(rd_data), 32'd0);

    // Read on empty after reset
    cycle(0, 16'h0, 1, 0);
    chk("udf_flag", 32'(underflow), 32'd1);
    chk("udf_rdata", 32'(rd_data), 32'h0);
    chk("udf_count", 32'(count), 32'd0);
    cycle(0, 16'h0, 0, 1);

    // Fill, overflow, drain in order
    for (int i = 1; i <= 4; i++) cycle(1, 16'(i), 0, 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_afull", 32'(almost_full), 32'd1);
    cycle(1, 16'h0005, 0, 0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 16'h0, 1, 0);
      chk("drain_rdata", 32'(rd_data), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);
    cycle(0, 16'h0, 0, 1);

    // Write/read pairs across pointer wrap
    for (int i = 0; i < 6; i++) begin
      cycle(1, 16'h00A0 + 16'(i), 0, 0);
      cycle(0, 16'h0, 1, 0);
      chk("wrap_rdata", 32'(rd_data), 32'h00A0 + 32'(i));
    end
    chk("wrap_ovf", 32'(overflow), 32'd0);
    chk("wrap_udf", 32'(underflow), 32'd0);

    // Full with simultaneous write and read
    cycle(0, 16'h0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(1, 16'h0010 + 16'(i), 0, 0);
    cycle(1, 16'hBEEF, 1, 0);
    chk("fullrw_count", 32'(count), 32'd4);
    chk("fullrw_ovf", 32'(overflow), 32'd0);
    chk("fullrw_rdata", 32'(rd_data), 32'h0010);
    for (int i = 1; i <= 3; i++) begin
      cycle(0, 16'h0, 1, 0);
      chk("fullrw_drain", 32'(rd_data), 32'h0010 + 32'(i));
    end
    cycle(0, 16'h0, 1, 0);
    chk("fullrw_last", 32'(rd_data), 32'hBEEF);

    // Empty with simultaneous write and read
    cycle(0, 16'h0, 0, 1);
    cycle(1, 16'h0077, 1, 0);
    chk("emptyrw_count", 32'(count), 32'd1);
    chk("emptyrw_udf", 32'(underflow), 32'd1);
    cycle(0, 16'h0, 1, 0);
    chk("emptyrw_rdata", 32'(rd_data), 32'h0077);

    // Reset discards in-flight words and clears sticky flags
    cycle(1, 16'h1234, 0, 0);
    cycle(1, 16'h5678, 0, 0);
    cycle(1, 16'h9999, 1, 1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    chk("rst_rdata", 32'(rd_data), 32'h0);
    cycle(0, 16'h0, 1, 0);
    chk("rst_no_stale", 32'(rd_data), 32'h0);
    model_on = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
